block_xfer_engine: RTL and testbench
====================================

// Module: block_xfer_engine
// PURPOSE
//  Parametrised memory-to-memory block-transfer sequencer for the z80 datapath.
//  Runs LDI/LDD/LDIR/LDDR as a hardware FSM: M_RD from src, M_WR to dst,
//  then updates the pointers and count (HL/DE/BC equivalents).
//  Sits between the control FSM and the external bus. Adds parametric widths,
//  T-state counts, wait insertion and abort over hand-sequenced control words.
// PARAMETERS
//  ADDR_W   16  address / pointer width
//  DATA_W   8   data width
//  CNT_W    16  transfer count width
//  RD_T     3   T-states per read cycle (>=2)
//  WR_T     3   T-states per write cycle (>=2)
// PORTS
//  clk        in   1       clock; all state changes on posedge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       start request; sampled only in IDLE
//  dir_dec    in   1       0: pointers increment (LDI); 1: decrement (LDD)
//  repeat     in   1       1: loop until count==0 (LDIR/LDDR)
//  abort      in   1       stop after the current byte's UPD
//  src_in     in   ADDR_W  initial source pointer (HL)
//  dst_in     in   ADDR_W  initial destination pointer (DE)
//  cnt_in     in   CNT_W   initial count (BC)
//  data_in    in   DATA_W  external data bus (read data)
//  wait_req   in   1       extend current bus cycle (Tw insertion)
//  addr_out   out  ADDR_W  external address bus
//  data_out   out  DATA_W  external write data
//  mreq       out  1       memory request strobe
//  rd         out  1       read strobe
//  wr         out  1       write strobe
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle completion pulse
//  pv         out  1       1 when updated count != 0 (Z80 P/V)
//  src_cur    out  ADDR_W  live source pointer
//  dst_cur    out  ADDR_W  live destination pointer
//  cnt_cur    out  CNT_W   live count
// BEHAVIOUR
//  Reset: all outputs, pointers, count and MDR = 0; state IDLE. Applies
//   mid-transfer: strobes drop on the next edge, no write completes.
//  States: IDLE -> RD -> WR -> UPD -> (RD | DONE) -> IDLE.
//  IDLE: start=1 loads src/dst/cnt from *_in, next state RD (tcount=0).
//   start while busy is ignored.
//  RD: addr_out=src_cur; mreq=rd=1 for all RD_T states. At tcount==1, if
//   wait_req=1 hold tcount (Tw, repeatable). Last T-state: MDR<=data_in.
//  WR: addr_out=dst_cur, data_out=MDR; mreq=1 all T-states; wr=1 from
//   tcount>=1. Wait handled as in RD. data_out held for the whole WR phase.
//  UPD (1 cycle, strobes low): src,dst +=1 (or -=1), modulo 2^ADDR_W (wrap
//   FFFF->0000, 0000->FFFF); cnt-=1 modulo 2^CNT_W; pv<=(cnt-1)!=0.
//   Next state RD if repeat && (cnt-1)!=0 && !abort; else DONE.
//  DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
//  cnt_in==0: first UPD wraps to 2^CNT_W-1, so repeat mode moves 2^CNT_W
//   bytes (Z80 semantics); non-repeat mode moves 1 byte with pv=1.
//  abort: takes effect only at UPD. The current byte always completes.
//   abort with repeat=0 has no effect.
//  Latency, no waits: start high in cycle 0 -> done high in cycle
//   RD_T+WR_T+2; each further repeat byte adds RD_T+WR_T+1 cycles.
//  Outside RD/WR: addr_out=0, data_out=0, mreq=rd=wr=0.
//  src/dst/cnt_cur hold final values in IDLE until the next start.
// TESTING
//  LDI: src=0x1000,dst=0x2000,cnt=3,data_in=0xEE -> wr at 0x2000 data 0xEE,
//   done in cycle 8, src=0x1001,dst=0x2001,cnt=2,pv=1.
//  LDIR cnt=4, memory model 0x10..0x13 at 0x1000 -> copied to 0x2000..0x2003,
//   cnt=0, pv=0, done once, total 4*7+1 cycles.
//  LDDR src=0x0001,dst=0xFFFF,cnt=3 -> pointers wrap to 0xFFFE/0xFFFC,
//   writes at 0xFFFF,0xFFFE,0xFFFD.
//  wait_req=1 for 2 cycles in RD T2 -> two Tw inserted; MDR captures
//   post-wait data; done is delayed by exactly 2 cycles.
//  LDIR cnt=10, abort pulse during 3rd byte's WR -> 3 bytes copied,
//   cnt=7, pv=1, done pulses.
//  rst during WR of byte 2 -> next cycle all outputs 0, IDLE; start
//   ignored while busy; cnt_in=0 with repeat=0 -> 1 byte, cnt=0xFFFF.

Source files
------------

// File: rtl/block_xfer_engine.sv
// Memory-to-memory block-transfer sequencer (LDI/LDD/LDIR/LDDR) driving an
// external bus with configurable read/write T-state counts and wait insertion.
module block_xfer_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int RD_T   = 3,
    parameter int WR_T   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir_dec,
    input  logic              repeat_mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wait_req,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              mreq,
    output logic              rd,
    output logic              wr,
    output logic              busy,
    output logic              done,
    output logic              pv,
    output logic [ADDR_W-1:0] src_cur,
    output logic [ADDR_W-1:0] dst_cur,
    output logic [CNT_W-1:0]  cnt_cur
);

    localparam int T_MAX = (RD_T > WR_T) ? RD_T : WR_T;
    localparam int T_W   = $clog2(T_MAX);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [T_W-1:0]    T_ZERO  = T_W'(32'd0);
    localparam logic [T_W-1:0]    T_ONE   = T_W'(32'd1);
    localparam logic [T_W-1:0]    RD_LAST = T_W'(RD_T - 1);
    localparam logic [T_W-1:0]    WR_LAST = T_W'(WR_T - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(32'd0);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  ZERO_C  = CNT_W'(32'd0);
    localparam logic [DATA_W-1:0] ZERO_D  = DATA_W'(32'd0);

    logic [2:0]        state_r, state_s;
    logic [T_W-1:0]    tcount_r, tcount_s;
    logic [ADDR_W-1:0] src_r, src_s;
    logic [ADDR_W-1:0] dst_r, dst_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [CNT_W-1:0]  cnt_dec_s;
    logic [DATA_W-1:0] mdr_r, mdr_s;
    logic              pv_r, pv_s;
    logic              dec_r, dec_s;
    logic              rep_r, rep_s;
    logic              abort_pend_r, abort_pend_s;
    logic              advance_s;
    logic              mreq_s, rd_s, wr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;

    // Sequencer next-state, pointer/count update and read-data capture
    always_comb begin
        state_s      = state_r;
        tcount_s     = tcount_r;
        src_s        = src_r;
        dst_s        = dst_r;
        cnt_s        = cnt_r;
        mdr_s        = mdr_r;
        pv_s         = pv_r;
        dec_s        = dec_r;
        rep_s        = rep_r;
        abort_pend_s = abort_pend_r;
        cnt_dec_s    = cnt_r - ONE_C;
        // Tw is only ever inserted at the second T-state of a bus cycle
        advance_s    = !((tcount_r == T_ONE) && wait_req);
        case (state_r)
            S_IDLE: begin
                abort_pend_s = 1'b0;
                if (start) begin
                    state_s  = S_RD;
                    tcount_s = T_ZERO;
                    src_s    = src_in;
                    dst_s    = dst_in;
                    cnt_s    = cnt_in;
                    dec_s    = dir_dec;
                    rep_s    = repeat_mode;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_RD: begin
                abort_pend_s = abort_pend_r | abort;
                if (advance_s) begin
                    if (tcount_r == RD_LAST) begin
                        state_s  = S_WR;
                        tcount_s = T_ZERO;
                        mdr_s    = data_in;
                    end else begin
                        tcount_s = tcount_r + T_ONE;
                    end
                end else begin
                    tcount_s = tcount_r;
                end
            end
            S_WR: begin
                abort_pend_s = abort_pend_r | abort;
                if (advance_s) begin
                    if (tcount_r == WR_LAST) begin
                        state_s  = S_UPD;
                        tcount_s = T_ZERO;
                    end else begin
                        tcount_s = tcount_r + T_ONE;
                    end
                end else begin
                    tcount_s = tcount_r;
                end
            end
            S_UPD: begin
                if (dec_r) begin
                    src_s = src_r - ONE_A;
                    dst_s = dst_r - ONE_A;
                end else begin
                    src_s = src_r + ONE_A;
                    dst_s = dst_r + ONE_A;
                end
                cnt_s    = cnt_dec_s;
                pv_s     = (cnt_dec_s != ZERO_C);
                tcount_s = T_ZERO;
                if (rep_r && (cnt_dec_s != ZERO_C) && !(abort || abort_pend_r)) begin
                    state_s = S_RD;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s  = S_IDLE;
                tcount_s = T_ZERO;
            end
        endcase
    end

    // Bus strobes decoded from the next state so the outputs can be registered
    always_comb begin
        mreq_s = 1'b0;
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        addr_s = ZERO_A;
        data_s = ZERO_D;
        case (state_s)
            S_RD: begin
                mreq_s = 1'b1;
                rd_s   = 1'b1;
                addr_s = src_s;
            end
            S_WR: begin
                mreq_s = 1'b1;
                wr_s   = (tcount_s != T_ZERO);
                addr_s = dst_s;
                data_s = mdr_s;
            end
            default: begin
                mreq_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            tcount_r     <= T_ZERO;
            src_r        <= ZERO_A;
            dst_r        <= ZERO_A;
            cnt_r        <= ZERO_C;
            mdr_r        <= ZERO_D;
            pv_r         <= 1'b0;
            dec_r        <= 1'b0;
            rep_r        <= 1'b0;
            abort_pend_r <= 1'b0;
            mreq         <= 1'b0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            addr_out     <= ZERO_A;
            data_out     <= ZERO_D;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_r      <= state_s;
            tcount_r     <= tcount_s;
            src_r        <= src_s;
            dst_r        <= dst_s;
            cnt_r        <= cnt_s;
            mdr_r        <= mdr_s;
            pv_r         <= pv_s;
            dec_r        <= dec_s;
            rep_r        <= rep_s;
            abort_pend_r <= abort_pend_s;
            mreq         <= mreq_s;
            rd           <= rd_s;
            wr           <= wr_s;
            addr_out     <= addr_s;
            data_out     <= data_s;
            busy         <= (state_s != S_IDLE);
            done         <= (state_s == S_DONE);
        end
    end

    assign pv      = pv_r;
    assign src_cur = src_r;
    assign dst_cur = dst_r;
    assign cnt_cur = cnt_r;

endmodule

// File: tb/tb_block_xfer_engine.sv
// Scoreboard bench for block_xfer_engine: directed transfers push expected
// writes/completions into queues, a negedge monitor pops and compares them.
module tb_block_xfer_engine;

    logic        clk = 1'b0;
    logic        rst, start, dir_dec, repeat_mode, abort, wait_req;
    logic [15:0] src_in, dst_in, cnt_in;
    logic [7:0]  data_in;
    logic [15:0] addr_out, src_cur, dst_cur, cnt_cur;
    logic [7:0]  data_out;
    logic        mreq, rd, wr, busy, done, pv;

    logic [7:0]  mem [0:65535];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_ev_t;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] cnt;
        logic        pv;
        int          cyc;
    } done_ev_t;

    wr_ev_t   exp_wr_q[$];
    done_ev_t exp_done_q[$];

    block_xfer_engine dut (
        .clk(clk), .rst(rst), .start(start), .dir_dec(dir_dec),
        .repeat_mode(repeat_mode), .abort(abort), .src_in(src_in),
        .dst_in(dst_in), .cnt_in(cnt_in), .data_in(data_in),
        .wait_req(wait_req), .addr_out(addr_out), .data_out(data_out),
        .mreq(mreq), .rd(rd), .wr(wr), .busy(busy), .done(done), .pv(pv),
        .src_cur(src_cur), .dst_cur(dst_cur), .cnt_cur(cnt_cur)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus data is garbage while a wait is held so MDR must capture post-wait data
    assign data_in = wait_req ? 8'hA5 : mem[addr_out];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(addr_out), 32'h0);
        chk({tag, "_data"}, 32'(data_out), 32'h0);
        chk({tag, "_mreq"}, 32'(mreq), 32'h0);
        chk({tag, "_rd"}, 32'(rd), 32'h0);
        chk({tag, "_wr"}, 32'(wr), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pv"}, 32'(pv), 32'h0);
        chk({tag, "_src"}, 32'(src_cur), 32'h0);
        chk({tag, "_dst"}, 32'(dst_cur), 32'h0);
        chk({tag, "_cnt"}, 32'(cnt_cur), 32'h0);
    endfunction

    // Queue the writes and the completion expected from a transfer started now
    task automatic expect_xfer(input logic [15:0] s, input logic [15:0] d, input logic dec,
                               input int nbytes, input logic [15:0] fs, input logic [15:0] fd,
                               input logic [15:0] fc, input logic fpv, input int lat);
        wr_ev_t   we;
        done_ev_t de;
        for (int i = 0; i < nbytes; i++) begin
            logic [15:0] a;
            a       = dec ? (s - 16'(i)) : (s + 16'(i));
            we.addr = dec ? (d - 16'(i)) : (d + 16'(i));
            we.data = mem[a];
            exp_wr_q.push_back(we);
        end
        de.src = fs;
        de.dst = fd;
        de.cnt = fc;
        de.pv  = fpv;
        de.cyc = cyc + lat;
        exp_done_q.push_back(de);
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c,
                            input logic dec, input logic rep);
        src_in      = s;
        dst_in      = d;
        cnt_in      = c;
        dir_dec     = dec;
        repeat_mode = rep;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        fails++;
        $display("FAIL %s_timeout: busy still 1 after 400 cycles, expected 0", tag);
    endtask

    // Monitor: compare every write strobe and completion pulse with the queues
    always @(negedge clk) begin : monitor
        wr_ev_t      we;
        done_ev_t    de;
        logic        wr_prev;
        logic        done_prev;
        logic [7:0]  cur_wdata;
        if (wr && !wr_prev) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected none", addr_out, data_out);
            end else begin
                we = exp_wr_q.pop_front();
                chk("wr_addr", 32'(addr_out), 32'(we.addr));
                chk("wr_data", 32'(data_out), 32'(we.data));
                chk("wr_mreq", 32'(mreq), 32'h1);
            end
            cur_wdata = data_out;
        end else if (wr && wr_prev) begin
            chk("wr_data_hold", 32'(data_out), 32'(cur_wdata));
        end
        if (done_prev) chk("done_one_cycle", 32'(done), 32'h0);
        if (done) begin
            if (exp_done_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: at cycle %0d, expected none", cyc);
            end else begin
                de = exp_done_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(de.cyc));
                chk("done_src", 32'(src_cur), 32'(de.src));
                chk("done_dst", 32'(dst_cur), 32'(de.dst));
                chk("done_cnt", 32'(cnt_cur), 32'(de.cnt));
                chk("done_pv", 32'(pv), 32'(de.pv));
                chk("done_busy", 32'(busy), 32'h1);
            end
        end
        wr_prev   = wr;
        done_prev = done;
    end

    initial begin
        rst = 1'b1; start = 1'b0; dir_dec = 1'b0; repeat_mode = 1'b0;
        abort = 1'b0; wait_req = 1'b0;
        src_in = 16'h0; dst_in = 16'h0; cnt_in = 16'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // LDI: one byte, count 3 -> 2
        mem[16'h1000] = 8'hEE;
        expect_xfer(16'h1000, 16'h2000, 1'b0, 1, 16'h1001, 16'h2001, 16'h0002, 1'b1, 8);
        do_start(16'h1000, 16'h2000, 16'h0003, 1'b0, 1'b0);
        wait_idle("ldi");
        repeat (2) @(negedge clk);
        chk("ldi_hold_src", 32'(src_cur), 32'h1001);
        chk("ldi_hold_cnt", 32'(cnt_cur), 32'h0002);

        // LDIR of 4 bytes with a start pulse while busy that must be ignored
        for (int i = 0; i < 4; i++) mem[16'h1000 + 16'(i)] = 8'h10 + 8'(i);
        expect_xfer(16'h1000, 16'h2000, 1'b0, 4, 16'h1004, 16'h2004, 16'h0000, 1'b0, 29);
        do_start(16'h1000, 16'h2000, 16'h0004, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        src_in = 16'hDEAD; dst_in = 16'hBEEF; cnt_in = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ldir");

        // LDDR across the address wrap
        mem[16'h0001] = 8'hA1; mem[16'h0000] = 8'hA2; mem[16'hFFFF] = 8'hA3;
        expect_xfer(16'h0001, 16'hFFFF, 1'b1, 3, 16'hFFFE, 16'hFFFC, 16'h0000, 1'b0, 22);
        do_start(16'h0001, 16'hFFFF, 16'h0003, 1'b1, 1'b1);
        wait_idle("lddr");

        // Two wait states at the read's second T-state delay done by 2 cycles
        mem[16'h3000] = 8'h5C;
        expect_xfer(16'h3000, 16'h4000, 1'b0, 1, 16'h3001, 16'h4001, 16'h0000, 1'b0, 10);
        do_start(16'h3000, 16'h4000, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        wait_req = 1'b1;
        repeat (2) @(negedge clk);
        wait_req = 1'b0;
        wait_idle("wait");

        // Abort pulse during the third byte's write phase
        for (int i = 0; i < 10; i++) mem[16'h5000 + 16'(i)] = 8'h20 + 8'(i);
        expect_xfer(16'h5000, 16'h6000, 1'b0, 3, 16'h5003, 16'h6003, 16'h0007, 1'b1, 22);
        do_start(16'h5000, 16'h6000, 16'h000A, 1'b0, 1'b1);
        repeat (18) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort");

        // Count of zero without repeat moves one byte and wraps the count
        mem[16'h7000] = 8'h77;
        expect_xfer(16'h7000, 16'h8000, 1'b0, 1, 16'h7001, 16'h8001, 16'hFFFF, 1'b1, 8);
        do_start(16'h7000, 16'h8000, 16'h0000, 1'b0, 1'b0);
        wait_idle("cnt0");

        // Reset in the write phase of byte 2: only byte 1 is written, no done
        for (int i = 0; i < 5; i++) mem[16'h9000 + 16'(i)] = 8'h90 + 8'(i);
        begin
            wr_ev_t we;
            we.addr = 16'hA000;
            we.data = 8'h90;
            exp_wr_q.push_back(we);
        end
        do_start(16'h9000, 16'hA000, 16'h0005, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("pre_rst_mreq", 32'(mreq), 32'h1);
        chk("pre_rst_addr", 32'(addr_out), 32'hA001);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'h0);

        chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'h0);
        chk("done_queue_empty", 32'(exp_done_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
